// File: rtl/decode_if.sv
// decode_if: handshake and control-bundle signals between fetch, decode and execute
interface decode_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [XLEN-1:0]  in_pc;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_pc;
    logic [1:0]       result_src;
    logic             mem_write;
    logic [4:0]       alu_control;
    logic             alu_src;
    logic [2:0]       immediate_control;
    logic             reg_write;
    logic             branch;
    logic [2:0]       branch_funct3;
    logic             jump;
    logic             illegal;
    logic [CNT_W-1:0] illegal_count;

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, result_src, mem_write, alu_control, alu_src,
               immediate_control, reg_write, branch, branch_funct3, jump, illegal, illegal_count
    );

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, result_src, mem_write, alu_control, alu_src,
               immediate_control, reg_write, branch, branch_funct3, jump, illegal, illegal_count
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: RV32I(M) instruction decode into a one-entry registered control bundle
module decode_stage #(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b0,
    parameter int CNT_W    = 8
) (
    input logic     clk,
    input logic     reset,
    decode_if.slave bus
);
    typedef struct packed {
        logic [1:0] rs;
        logic       mw;
        logic [4:0] alu;
        logic       asrc;
        logic [2:0] imm;
        logic       rw;
        logic       br;
        logic [2:0] bf3;
        logic       jmp;
        logic       ill;
    } ctl_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_AND   = 5'd2;
    localparam logic [4:0] ALU_OR    = 5'd3;
    localparam logic [4:0] ALU_XOR   = 5'd4;
    localparam logic [4:0] ALU_SLL   = 5'd5;
    localparam logic [4:0] ALU_SRL   = 5'd6;
    localparam logic [4:0] ALU_SRA   = 5'd7;
    localparam logic [4:0] ALU_SLT   = 5'd8;
    localparam logic [4:0] ALU_SLTU  = 5'd9;
    localparam logic [4:0] ALU_PASSB = 5'd10;

    logic [6:0]       op;
    logic [6:0]       f7;
    logic [2:0]       f3;
    logic [4:0]       base_alu;
    logic             accept;
    ctl_t             dec;
    ctl_t             bundle_d, bundle_q;
    logic [XLEN-1:0]  pc_d, pc_q;
    logic             valid_d, valid_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    assign op = bus.in_instr[6:0];
    assign f3 = bus.in_instr[14:12];
    assign f7 = bus.in_instr[31:25];

    // funct3 to ALU op for the plain (funct7 = 0) register/immediate forms
    always_comb begin
        base_alu = f3 == 3'd0 ? ALU_ADD  :
                   f3 == 3'd1 ? ALU_SLL  :
                   f3 == 3'd2 ? ALU_SLT  :
                   f3 == 3'd3 ? ALU_SLTU :
                   f3 == 3'd4 ? ALU_XOR  :
                   f3 == 3'd5 ? ALU_SRL  :
                   f3 == 3'd6 ? ALU_OR   : ALU_AND;
    end

    // combinational decode of the incoming word; unrecognised words leave only ill set
    always_comb begin
        dec = '0;
        case (op)
            OP_R: begin
                if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
                    dec.alu = f7[5] ? (f3 == 3'd0 ? ALU_SUB : ALU_SRA) : base_alu;
                    dec.rw  = 1'b1;
                end else if (f7 == 7'h01 && ENABLE_M) begin
                    dec.alu = 5'd16 + {2'b00, f3};
                    dec.rw  = 1'b1;
                end else begin
                    dec.ill = 1'b1;
                end
            end
            OP_I: begin
                if ((f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20)) begin
                    dec.ill = 1'b1;
                end else begin
                    dec.alu  = (f3 == 3'd5 && f7[5]) ? ALU_SRA : base_alu;
                    dec.asrc = 1'b1;
                    dec.rw   = 1'b1;
                end
            end
            OP_LOAD: begin
                dec.asrc = 1'b1;
                dec.rs   = 2'd1;
                dec.rw   = 1'b1;
            end
            OP_STORE: begin
                dec.asrc = 1'b1;
                dec.imm  = 3'd1;
                dec.mw   = 1'b1;
            end
            OP_BRANCH: begin
                if (f3 == 3'd2 || f3 == 3'd3) begin
                    dec.ill = 1'b1;
                end else begin
                    dec.alu = ALU_SUB;
                    dec.imm = 3'd2;
                    dec.br  = 1'b1;
                    dec.bf3 = f3;
                end
            end
            OP_JAL: begin
                dec.imm = 3'd3;
                dec.rs  = 2'd2;
                dec.jmp = 1'b1;
                dec.rw  = 1'b1;
            end
            OP_JALR: begin
                dec.asrc = 1'b1;
                dec.rs   = 2'd2;
                dec.jmp  = 1'b1;
                dec.rw   = 1'b1;
            end
            OP_LUI: begin
                dec.alu  = ALU_PASSB;
                dec.imm  = 3'd4;
                dec.asrc = 1'b1;
                dec.rw   = 1'b1;
            end
            OP_AUIPC: begin
                dec.imm  = 3'd4;
                dec.asrc = 1'b1;
                dec.rw   = 1'b1;
            end
            default: dec.ill = 1'b1;
        endcase
    end

    // output-register next state: flush wins, then accept, otherwise hold until handed off
    always_comb begin
        accept   = bus.in_valid && bus.in_ready && !bus.flush;
        bundle_d = accept ? dec : bundle_q;
        pc_d     = accept ? bus.in_pc : pc_q;
        valid_d  = bus.flush ? 1'b0 : accept ? 1'b1 : valid_q && !bus.out_ready;
        cnt_d    = (accept && dec.ill && cnt_q != {CNT_W{1'b1}}) ? cnt_q + 1'b1 : cnt_q;
    end

    // state registers, cleared asynchronously while reset is low
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bundle_q <= '0;
            pc_q     <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            bundle_q <= bundle_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.in_ready          = !valid_q || bus.out_ready;
    assign bus.out_valid         = valid_q;
    assign bus.out_pc            = pc_q;
    assign bus.result_src        = bundle_q.rs;
    assign bus.mem_write         = bundle_q.mw;
    assign bus.alu_control       = bundle_q.alu;
    assign bus.alu_src           = bundle_q.asrc;
    assign bus.immediate_control = bundle_q.imm;
    assign bus.reg_write         = bundle_q.rw;
    assign bus.branch            = bundle_q.br;
    assign bus.branch_funct3     = bundle_q.bf3;
    assign bus.jump              = bundle_q.jmp;
    assign bus.illegal           = bundle_q.ill;
    assign bus.illegal_count     = cnt_q;
endmodule
